mlp_r_stream_frontend: RTL and testbench

- Hardware front/back end for the combinational regression MLP `top` (inp = NUM_A×WIDTH_A packed features, out = unsigned Q(OUTWIDTH-FRAC_W).FRAC_W value).
- Accepts features one per cycle over a valid/ready stream and packs them into the classifier input vector.
- Waits a fixed settle time, captures the classifier output, and rounds it to an integer class with saturation.
- Presents the class and the raw output on a valid/ready result stream; replaces file-driven stimulus in on-board and system runs.

---
 rtl/mlp_r_stream_frontend.sv | 127 ++++++++++++
 tb/tb_mlp_r_stream_frontend.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_r_stream_frontend.sv
// Stream front/back end for the combinational regression MLP: packs features into
// the classifier input, waits a settle time, then rounds and saturates the output.
module mlp_r_stream_frontend #(
    parameter int WIDTH_A    = 4,
    parameter int NUM_A      = 21,
    parameter int OUTWIDTH   = 22,
    parameter int FRAC_W     = 16,
    parameter int MAX_CLASS  = 3,
    parameter int CLASS_W    = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     feat_valid,
    input  logic [WIDTH_A-1:0]       feat_data,
    output logic                     feat_ready,
    output logic [NUM_A*WIDTH_A-1:0] clf_inp,
    input  logic [OUTWIDTH-1:0]      clf_out,
    output logic                     res_valid,
    output logic [CLASS_W-1:0]       res_class,
    output logic [OUTWIDTH-1:0]      res_raw,
    input  logic                     res_ready,
    output logic                     busy
);
    localparam int IW    = OUTWIDTH - FRAC_W;
    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_A - 1);
    localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(SETTLE_CYC - 1);
    localparam logic [FRAC_W-1:0] HALF      = {1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, SETTLE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NUM_A*WIDTH_A-1:0] lanes_q, lanes_d;
    logic                     res_valid_q, res_valid_d;
    logic [CLASS_W-1:0]       res_class_q, res_class_d;
    logic [OUTWIDTH-1:0]      res_raw_q, res_raw_d;

    logic [IW-1:0]      ip;
    logic [FRAC_W-1:0]  fr;
    logic               up;
    logic [IW:0]        rnd;
    logic [CLASS_W-1:0] cls;

    // Round half down (strict compare), then clamp to the top class.
    assign ip  = clf_out[OUTWIDTH-1:FRAC_W];
    assign fr  = clf_out[FRAC_W-1:0];
    assign up  = (fr > HALF);
    assign rnd = {1'b0, ip} + (IW+1)'(up);
    assign cls = (rnd > (IW+1)'(MAX_CLASS)) ? CLASS_W'(MAX_CLASS) : rnd[CLASS_W-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lanes_d     = lanes_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_raw_d   = res_raw_q;
        case (state_q)
            LOAD: begin
                if (feat_valid) begin
                    for (int k = 0; k < NUM_A; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            lanes_d[k*WIDTH_A +: WIDTH_A] = feat_data;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        cnt_d   = CNT_START;
                        state_d = SETTLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_raw_d   = clf_out;
                    res_class_d = cls;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            lanes_q     <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_raw_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lanes_q     <= lanes_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_raw_q   <= res_raw_d;
        end
    end

    assign feat_ready = !rst && (state_q == LOAD);
    assign busy       = !rst && (state_q != LOAD);
    assign clf_inp    = lanes_q;
    assign res_valid  = res_valid_q;
    assign res_class  = res_class_q;
    assign res_raw    = res_raw_q;
endmodule

// File: tb/tb_mlp_r_stream_frontend.sv
// Directed bench for mlp_r_stream_frontend: lane packing, rounding/saturation,
// settle latency, result backpressure, mid-sample reset and back-to-back throughput.
module tb_mlp_r_stream_frontend;
    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic [3:0]  feat_data;
    logic        feat_ready;
    logic [83:0] clf_inp;
    logic [21:0] clf_out;
    logic        res_valid;
    logic [1:0]  res_class;
    logic [21:0] res_raw;
    logic        res_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int         res_cyc[$];
    logic [1:0] res_cls[$];

    mlp_r_stream_frontend #(
        .WIDTH_A(4), .NUM_A(21), .OUTWIDTH(22), .FRAC_W(16),
        .MAX_CLASS(3), .CLASS_W(2), .SETTLE_CYC(4)
    ) dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(feat_ready),
        .clf_inp(clf_inp), .clf_out(clf_out),
        .res_valid(res_valid), .res_class(res_class), .res_raw(res_raw),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Logs every accepted result so throughput can be checked afterwards.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            res_cyc.push_back(cyc);
            res_cls.push_back(res_class);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [83:0] expLanes(input int base);
        logic [83:0] v;
        v = '0;
        for (int k = 0; k < 21; k++) v[k*4 +: 4] = 4'(base + k);
        return v;
    endfunction

    task automatic applyStimulus(input logic [3:0] d, input int gap);
        int n;
        feat_valid = 1'b0;
        repeat (gap) step();
        feat_valid = 1'b1;
        feat_data  = d;
        n = 0;
        while (feat_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n == 100) checkOutput("feat_ready_timeout", 0, 1);
        step();
        feat_valid = 1'b0;
    endtask

    task automatic sendSample(input int base, input bit gapped);
        for (int k = 0; k < 21; k++)
            applyStimulus(4'(base + k), gapped ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic waitResult(input string tag, output int at);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        at = cyc;
        if (n == 200) checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    task automatic releaseResult();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checkOutput("release_valid", res_valid, 0);
        checkOutput("release_load", feat_ready, 1);
    endtask

    task automatic runRound(input string tag, input logic [21:0] v, input logic [1:0] exp_cls);
        int at;
        clf_out = v;
        sendSample(3, 1'b0);
        waitResult(tag, at);
        checkOutput({tag, "_class"}, res_class, exp_cls);
        checkOutput({tag, "_raw"}, res_raw, v);
        releaseResult();
    endtask

    initial begin
        int e, t, at;
        logic [21:0] b2b_val [3];
        logic [1:0]  b2b_exp [3];

        rst        = 1'b1;
        feat_valid = 1'b0;
        feat_data  = '0;
        res_ready  = 1'b0;
        clf_out    = '0;
        step();
        step();
        checkOutput("rst_feat_ready", feat_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_class", res_class, 0);
        checkOutput("rst_res_raw", res_raw, 0);
        checkOutput("rst_lanes", clf_inp, 0);
        rst = 1'b0;
        step();
        checkOutput("load_ready", feat_ready, 1);

        // Lane order with a zero classifier output.
        clf_out = '0;
        sendSample(1, 1'b0);
        checkOutput("lane_order", clf_inp, expLanes(1));
        checkOutput("settle_busy", busy, 1);
        checkOutput("settle_ready", feat_ready, 0);
        waitResult("lane", at);
        checkOutput("lane_class", res_class, 0);
        checkOutput("lane_raw", res_raw, 0);
        releaseResult();

        runRound("rnd_up", 22'h18001, 2'd2);
        runRound("rnd_half", 22'h28000, 2'd2);
        runRound("rnd_down", 22'h17FFF, 2'd1);
        runRound("rnd_half0", 22'h08000, 2'd0);
        runRound("sat_3c", 22'h3C000, 2'd3);
        runRound("sat_max", 22'h3FFFFF, 2'd3);
        runRound("sat_5", 22'h50000, 2'd3);
        runRound("sat_rndup", 22'h2C000, 2'd3);

        // Gapped feed, settle latency and result backpressure.
        clf_out = 22'h18001;
        sendSample(5, 1'b1);
        e = cyc;
        checkOutput("gap_lanes", clf_inp, expLanes(5));
        waitResult("gap", t);
        checkOutput("gap_latency", t - e, 4);
        clf_out = 22'h3FFFFF;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("hold_valid", res_valid, 1);
            checkOutput("hold_class", res_class, 2);
            checkOutput("hold_raw", res_raw, 22'h18001);
            checkOutput("hold_ready", feat_ready, 0);
            checkOutput("hold_busy", busy, 1);
        end
        releaseResult();

        // Reset in the middle of a sample drops it.
        clf_out = 22'h3C000;
        for (int k = 0; k < 10; k++) applyStimulus(4'hA, 0);
        rst = 1'b1;
        step();
        checkOutput("midrst_ready", feat_ready, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_lanes", clf_inp, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("midrst_no_result", res_valid, 0);
        end
        checkOutput("midrst_load", feat_ready, 1);
        sendSample(7, 1'b0);
        checkOutput("midrst_lanes_new", clf_inp, expLanes(7));
        waitResult("midrst", at);
        checkOutput("midrst_class", res_class, 3);
        checkOutput("midrst_raw", res_raw, 22'h3C000);
        releaseResult();

        // Back-to-back samples with the consumer always ready.
        b2b_val[0] = 22'h08001; b2b_exp[0] = 2'd1;
        b2b_val[1] = 22'h2C000; b2b_exp[1] = 2'd3;
        b2b_val[2] = 22'h28000; b2b_exp[2] = 2'd2;
        res_cyc.delete();
        res_cls.delete();
        res_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            clf_out = b2b_val[s];
            sendSample(s, 1'b0);
            waitResult("b2b", at);
        end
        step();
        step();
        res_ready = 1'b0;
        checkOutput("b2b_count", res_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < res_cls.size()) checkOutput("b2b_class", res_cls[i], b2b_exp[i]);
            if (i > 0 && i < res_cyc.size()) checkOutput("b2b_spacing", res_cyc[i] - res_cyc[i-1], 26);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
